// File: rtl/mult_div_pkg.sv
// Shared encodings for the multicycle multiply/divide unit: opcodes, FSM states
// and small opcode decode helpers.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_FIX  = 2'b11
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the CPU control/datapath and the mult/div unit.
// The master launches operations; the slave reports busy/done and holds HI/LO.
interface mult_div_if #(parameter int WIDTH = 32);
  import mult_div_pkg::*;

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);

endinterface

// File: rtl/md_negate.sv
// Conditional two's-complement negate, purely combinational.
module md_negate #(parameter int N = 64) (
  input  logic         neg_i,
  input  logic [N-1:0] dat_i,
  output logic [N-1:0] dat_o
);

  assign dat_o = neg_i ? ({N{1'b0}} - dat_i) : dat_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU, one bit per clock on operand magnitudes.
// Shared 2*WIDTH accumulator; sign fix-up applied once in FIX before HI/LO update.
module mult_div_unit #(parameter int WIDTH = 32) (
  input logic        clk,
  input logic        reset,
  mult_div_if.slave  md
);
  import mult_div_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op_q;
  logic             sa_q, sb_q;
  logic [WIDTH-1:0] b_q;
  logic [W2-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dz_q;

  logic             start_acc;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [W2-1:0]    mul_nxt, div_nxt;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign start_acc = (state_q == ST_IDLE) && md.start;
  assign a_neg     = is_signed_op(md.op) && md.a[WIDTH-1];
  assign b_neg     = is_signed_op(md.op) && md.b[WIDTH-1];

  md_negate #(.N(WIDTH)) u_abs_a (.neg_i(a_neg), .dat_i(md.a), .dat_o(a_mag));
  md_negate #(.N(WIDTH)) u_abs_b (.neg_i(b_neg), .dat_i(md.b), .dat_o(b_mag));

  // Shift-add keeps the carry out of the upper half; restoring divide needs one extra bit.
  assign mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, b_q};
  assign mul_nxt   = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
  assign div_trial = acc_q[W2-1:WIDTH-1] - {1'b0, b_q};
  assign div_nxt   = div_trial[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  md_negate #(.N(W2)) u_neg_prod (
    .neg_i ((op_q == OP_MULT) && (sa_q ^ sb_q)),
    .dat_i (acc_q),
    .dat_o (prod_fix)
  );
  md_negate #(.N(WIDTH)) u_neg_quo (
    .neg_i ((op_q == OP_DIV) && (sa_q ^ sb_q)),
    .dat_i (acc_q[WIDTH-1:0]),
    .dat_o (quo_fix)
  );
  md_negate #(.N(WIDTH)) u_neg_rem (
    .neg_i ((op_q == OP_DIV) && sa_q),
    .dat_i (acc_q[W2-1:WIDTH]),
    .dat_o (rem_fix)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_acc) state_d = ST_LOAD;
      ST_LOAD: state_d = (is_div(op_q) && (b_q == '0)) ? ST_FIX : ST_RUN;
      ST_RUN:  if (cnt_q == CW'(1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= OP_MULT;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FIX);
      case (state_q)
        ST_IDLE: if (start_acc) begin
          op_q  <= md.op;
          sa_q  <= a_neg;
          sb_q  <= b_neg;
          b_q   <= b_mag;
          acc_q <= {{WIDTH{1'b0}}, a_mag};
          dz_q  <= 1'b0;
        end
        ST_LOAD: begin
          if (is_div(op_q) && (b_q == '0)) dz_q  <= 1'b1;
          else                             cnt_q <= CW'(WIDTH);
        end
        ST_RUN: begin
          acc_q <= is_div(op_q) ? div_nxt : mul_nxt;
          cnt_q <= cnt_q - CW'(1);
        end
        ST_FIX: if (!dz_q) begin
          // HI/LO only change here, so the CPU never observes partial results.
          if (is_div(op_q)) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[W2-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign md.busy     = (state_q != ST_IDLE);
  assign md.done     = done_q;
  assign md.div_zero = dz_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed checks of mult_div_unit at WIDTH=32 and WIDTH=8
// against an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(32)) if32();
  mult_div_if #(.WIDTH(8))  if8();

  mult_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst_n), .md(if32));
  mult_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst_n), .md(if8));

  logic        sel8 = 1'b0;
  logic        start_r = 1'b0;
  logic [1:0]  op_r = 2'b00;
  logic [31:0] a_r = '0, b_r = '0;

  assign if32.start = start_r & ~sel8;
  assign if8.start  = start_r & sel8;
  assign if32.op    = op_e'(op_r);
  assign if8.op     = op_e'(op_r);
  assign if32.a     = a_r;
  assign if32.b     = b_r;
  assign if8.a      = a_r[7:0];
  assign if8.b      = b_r[7:0];

  logic        cur_busy, cur_done, cur_dz;
  logic [31:0] cur_hi, cur_lo;
  assign cur_busy = sel8 ? if8.busy     : if32.busy;
  assign cur_done = sel8 ? if8.done     : if32.done;
  assign cur_dz   = sel8 ? if8.div_zero : if32.div_zero;
  assign cur_hi   = sel8 ? {24'd0, if8.hi} : if32.hi;
  assign cur_lo   = sel8 ? {24'd0, if8.lo} : if32.lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on w-bit values held in 64 bits.
  function automatic void ref_md(input int w, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] hi,
                                 output logic [31:0] lo);
    logic [63:0] mask, ua, ub, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ua[w-1] ? ($signed(ua) - (longint'(1) << w)) : $signed(ua);
    sb = ub[w-1] ? ($signed(ub) - (longint'(1) << w)) : $signed(ub);
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = 32'((p >> w) & mask); lo = 32'(p & mask); end
      2'b01: begin p = ua * ub;      hi = 32'((p >> w) & mask); lo = 32'(p & mask); end
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        lo = 32'(64'(q) & mask);
        hi = 32'(64'(r) & mask);
      end
      default: begin lo = 32'((ua / ub) & mask); hi = 32'((ua % ub) & mask); end
    endcase
  endfunction

  task automatic do_op(input bit s8, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit poke, input bit gap);
    int          w, n, lat, idx;
    logic        dz;
    logic [31:0] m, eh, el;
    idx = s8 ? 1 : 0;
    w   = s8 ? 8 : 32;
    m   = s8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
    dz  = op[1] && ((b & m) == 32'd0);
    if (dz) begin
      eh = m_hi[idx]; el = m_lo[idx]; lat = 2;
    end else begin
      ref_md(w, op, a, b, eh, el); lat = w + 2;
    end
    sel8 = s8; op_r = op; a_r = a; b_r = b; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    check("busy_after_start", cur_busy, 1);
    n = 0;
    while (!cur_done && n < 100) begin
      start_r = poke && !dz && (n == 3);
      a_r = $urandom; b_r = $urandom; op_r = 2'($urandom);
      @(negedge clk);
      n++;
    end
    start_r = 1'b0;
    check("done_latency", n, lat);
    check("busy_at_done", cur_busy, 0);
    check("hi", cur_hi, eh);
    check("lo", cur_lo, el);
    check("div_zero", cur_dz, dz);
    m_hi[idx] = eh;
    m_lo[idx] = el;
    if (gap) begin
      @(negedge clk);
      check("done_one_cycle", cur_done, 0);
    end
  endtask

  initial begin
    int nd, kind;
    logic [1:0]  op;
    logic [31:0] a, b;
    bit s8;
    m_hi[0] = '0; m_hi[1] = '0; m_lo[0] = '0; m_lo[1] = '0;

    repeat (2) @(negedge clk);
    check("rst32_busy", if32.busy, 0);
    check("rst32_done", if32.done, 0);
    check("rst32_dz",   if32.div_zero, 0);
    check("rst32_hi",   if32.hi, 0);
    check("rst32_lo",   if32.lo, 0);
    check("rst8_hilo",  {if8.hi, if8.lo, if8.busy, if8.done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(0, OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 0, 1);
    do_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    do_op(0, OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    do_op(0, OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 1);
    do_op(0, OP_DIVU,  32'd100,       32'd7,         0, 1);
    do_op(0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    do_op(0, OP_DIVU,  32'h0000_1234, 32'h0000_0000, 0, 1);
    do_op(0, OP_MULTU, 32'd3,         32'd4,         0, 1);

    do_op(1, OP_MULT, 32'h80, 32'h80, 0, 0);
    do_op(1, OP_DIV,  32'h80, 32'hFF, 0, 1);
    do_op(1, OP_DIVU, 32'h37, 32'h00, 0, 0);
    do_op(1, OP_MULTU, 32'hFF, 32'hFF, 0, 1);

    // Abort a 32-bit multiply partway through RUN.
    sel8 = 1'b0; op_r = OP_MULT; a_r = 32'h1234_5678; b_r = 32'h9ABC_DEF0; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", if32.busy, 0);
    check("midrst_done", if32.done, 0);
    check("midrst_dz",   if32.div_zero, 0);
    check("midrst_hi",   if32.hi, 0);
    check("midrst_lo",   if32.lo, 0);
    check("midrst_hi8",  if8.hi, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (if32.done) nd++;
    end
    check("midrst_no_done", nd, 0);
    m_hi[0] = '0; m_hi[1] = '0; m_lo[0] = '0; m_lo[1] = '0;

    for (int i = 0; i < 60; i++) begin
      s8   = 1'($urandom_range(0, 1));
      op   = 2'($urandom);
      kind = $urandom_range(0, 7);
      a    = $urandom;
      b    = $urandom;
      case (kind)
        0: b = 32'd0;
        1: begin
          a = s8 ? 32'h80 : 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = s8 ? 32'h0000_0080 : 32'h8000_0000;
        default: ;
      endcase
      do_op(s8, op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
